// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } state_e;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   // Fetches always read a full word; sliced down to the byte-enable width.
   localparam logic [31:0] FETCH_BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data channels and memory-side bus of the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   logic              d_req;
   logic              d_we;
   logic [BE_W-1:0]   d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              m_req;
   logic              m_we;
   logic [BE_W-1:0]   m_be;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ack;

   logic              stall;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
      output if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_be, m_addr, m_wdata, stall
   );

   // Core + memory side.
   modport master (
      output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
      input  if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_be, m_addr, m_wdata, stall
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests.
// MEM_ARB_RR_EN: alternate on ties using a last-grant flop; otherwise data always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic d_req,
   input  logic grant_en,
   output logic any,
   output logic win
);
   assign any = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   logic last_grant_q, last_grant_d;

   always_comb begin
      win = d_req ? GNT_D : GNT_IF;
      if (if_req && d_req)
         win = (last_grant_q == GNT_D) ? GNT_IF : GNT_D;
      last_grant_d = grant_en ? win : last_grant_q;
   end

   // Reset to DATA so the first tie goes to fetch.
   always_ff @(posedge clk) begin
      if (!reset) last_grant_q <= GNT_D;
      else        last_grant_q <= last_grant_d;
   end
`else
   logic unused_pick;
   assign unused_pick = ^{clk, reset, grant_en, if_req};

   always_comb begin
      win = d_req ? GNT_D : GNT_IF;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Build option MEM_ARB_RR_EN (handled in mem_arb_pick) selects round-robin on ties.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;

   state_e            state_q, state_d;
   logic              m_we_q, m_we_d;
   logic [BE_W-1:0]   m_be_q, m_be_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

   logic pick_any, pick_win, grant_en;

   assign grant_en = (state_q == IDLE) && pick_any;

   mem_arb_pick u_pick (
      .clk      (clk),
      .reset    (reset),
      .if_req   (bus.if_req),
      .d_req    (bus.d_req),
      .grant_en (grant_en),
      .any      (pick_any),
      .win      (pick_win)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         m_we_q    <= 1'b0;
         m_be_q    <= '0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         m_we_q    <= m_we_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:            if (pick_any) state_d = (pick_win == GNT_D) ? BUSY_D : BUSY_IF;
         BUSY_IF, BUSY_D: if (bus.m_ack) state_d = IDLE;
         default:         state_d = IDLE;
      endcase
   end

   // Attributes are captured only on the IDLE grant and held through BUSY.
   always_comb begin
      m_we_d    = m_we_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      if (grant_en) begin
         if (pick_win == GNT_D) begin
            m_we_d    = bus.d_we;
            m_be_d    = bus.d_be;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
         end else begin
            m_we_d    = 1'b0;
            m_be_d    = FETCH_BE_ALL[BE_W-1:0];
            m_addr_d  = bus.if_addr;
            m_wdata_d = '0;
         end
      end
   end

   // Gating with reset keeps a late ack during reset from producing a ready.
   always_comb begin
      bus.m_req    = reset && (state_q != IDLE);
      bus.if_ready = reset && (state_q == BUSY_IF) && bus.m_ack;
      bus.d_ready  = reset && (state_q == BUSY_D)  && bus.m_ack;
   end

   assign bus.m_we     = m_we_q;
   assign bus.m_be     = m_be_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.if_rdata = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;
   assign bus.stall    = (bus.if_req & ~bus.if_ready) | (bus.d_req & ~bus.d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a transaction-level model and memory.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [16];

   // transaction model
   bit          mbusy, mfirst, mch, last_g;
   logic [31:0] e_addr, e_wdata;
   logic        e_we;
   logic [3:0]  e_be;

   // memory responder / requester control
   bit  rsp_on, ack_force, junk_ack;
   int  wait_left, force_lat = -1;
   int  if_rate = 0, d_rate = 0;
   bit  done_if, done_d;
   logic [31:0] gnt_log [$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic int idx(logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   // Fetch addresses have bit 6 set, data addresses clear, so m_addr[6] identifies the channel.
   task automatic new_if(logic [31:0] a);
      bus.if_req  = 1'b1;
      bus.if_addr = a;
   endtask

   task automatic new_d(logic we, logic [3:0] be, logic [31:0] a, logic [31:0] wd);
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_be    = be;
      bus.d_addr  = a;
      bus.d_wdata = wd;
   endtask

   task automatic rand_d();
      int lane;
      logic [3:0] be;
      lane = $urandom_range(0, 3);
      be   = $urandom_range(0, 1) ? 4'hF : (4'b0001 << lane);
      new_d(1'($urandom_range(0, 1)), be, (32'($urandom_range(0, 15)) << 2) | 32'(lane), $urandom);
   endtask

   task automatic tick();
      @(negedge clk);
      if (done_if) bus.if_req = 1'b0;
      if (done_d)  bus.d_req  = 1'b0;
      if (!bus.if_req && $urandom_range(0, 99) < if_rate)
         new_if(32'h40 | (32'($urandom_range(0, 15)) << 2));
      if (!bus.d_req && $urandom_range(0, 99) < d_rate)
         rand_d();
   endtask

   task automatic eval();
      logic exp_ifr, exp_dr, exp_stall;
      logic [31:0] w;
      #1;
      bus.m_ack   = 1'b0;
      bus.m_rdata = $urandom;
      if (!reset) begin
         bus.m_ack = ack_force;
         rsp_on    = 1'b0;
      end else if (bus.m_req) begin
         if (!rsp_on) begin
            rsp_on    = 1'b1;
            wait_left = (force_lat >= 0) ? force_lat : $urandom_range(0, 2);
            gnt_log.push_back(bus.m_addr);
         end
         if (wait_left == 0) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = mem[idx(bus.m_addr)];
            rsp_on      = 1'b0;
         end else begin
            wait_left--;
         end
      end else if (junk_ack) begin
         bus.m_ack = ($urandom_range(0, 3) == 0);
      end
      #1;
      chk("m_req", 32'(bus.m_req), 32'(reset && mbusy));
      if (mfirst) begin
         chk("m_addr", bus.m_addr, e_addr);
         chk("m_we", 32'(bus.m_we), 32'(e_we));
         chk("m_be", 32'(bus.m_be), 32'(e_be));
         if (e_we) chk("m_wdata", bus.m_wdata, e_wdata);
         mfirst = 1'b0;
      end
      exp_ifr = reset && mbusy && (mch == GNT_IF) && bus.m_ack;
      exp_dr  = reset && mbusy && (mch == GNT_D)  && bus.m_ack;
      chk("if_ready", 32'(bus.if_ready), 32'(exp_ifr));
      chk("d_ready", 32'(bus.d_ready), 32'(exp_dr));
      w = mem[idx(e_addr)];
      if (exp_ifr) chk("if_rdata", bus.if_rdata, w);
      if (exp_dr && !e_we) chk("d_rdata", bus.d_rdata, w);
      exp_stall = (bus.if_req && !exp_ifr) || (bus.d_req && !exp_dr);
      chk("stall", 32'(bus.stall), 32'(exp_stall));
      if (exp_dr && e_we)
         for (int b = 0; b < 4; b++)
            if (e_be[b]) mem[idx(e_addr)][8*b +: 8] = e_wdata[8*b +: 8];
      done_if = exp_ifr;
      done_d  = exp_dr;
      // one transaction at a time; a new one is granted from an idle cycle
      if (!reset) begin
         mbusy  = 1'b0;
         last_g = GNT_D;
      end else if (mbusy) begin
         if (bus.m_ack) mbusy = 1'b0;
      end else if (bus.if_req || bus.d_req) begin
         mch = bus.d_req ? GNT_D : GNT_IF;
`ifdef MEM_ARB_RR_EN
         if (bus.if_req && bus.d_req) mch = (last_g == GNT_D) ? GNT_IF : GNT_D;
         last_g = mch;
`endif
         mbusy  = 1'b1;
         mfirst = 1'b1;
         if (mch == GNT_D) begin
            e_addr = bus.d_addr; e_we = bus.d_we; e_be = bus.d_be; e_wdata = bus.d_wdata;
         end else begin
            e_addr = bus.if_addr; e_we = 1'b0; e_be = 4'hF; e_wdata = '0;
         end
      end
   endtask

   task automatic cyc();
      tick();
      eval();
   endtask

   initial begin
      int pulses, rdy_at;
      bus.if_req = 0; bus.if_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
      bus.m_ack = 0; bus.m_rdata = 0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;

      // 1: reset with both requests and a stuck ack
      tick(); reset = 0; ack_force = 1; new_if(32'h44); new_d(1'b1, 4'hF, 32'h200, 32'h1234_5678); eval();
      cyc(); cyc();
      chk("rst_m_addr", bus.m_addr, 32'h0);
      chk("rst_m_we", 32'(bus.m_we), 32'h0);
      chk("rst_m_be", 32'(bus.m_be), 32'h0);
      chk("rst_m_wdata", bus.m_wdata, 32'h0);
      tick(); reset = 1; ack_force = 0; bus.if_req = 0; bus.d_req = 0; eval();

      // 2: single fetch, memory acks two cycles after m_req
      mem[idx(32'h40)] = 32'h0050_0093;
      force_lat = 2; gnt_log.delete();
      tick(); new_if(32'h40); eval();
      pulses = 0; rdy_at = -1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (bus.if_ready) begin
            pulses++; rdy_at = i;
            chk("t2_rdata", bus.if_rdata, 32'h0050_0093);
         end
      end
      chk("t2_pulses", 32'(pulses), 32'd1);
      chk("t2_latency", 32'(rdy_at), 32'd2);
      chk("t2_grants", 32'(gnt_log.size()), 32'd1);
      if (gnt_log.size() > 0) chk("t2_addr", gnt_log[0], 32'h40);

      // 3: byte store, ack in the first m_req cycle
      force_lat = 0; pulses = 0;
      tick(); new_d(1'b1, 4'b0100, 32'h102, 32'h00AB_0000); eval();
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (bus.m_req) begin
            chk("t3_we", 32'(bus.m_we), 32'd1);
            chk("t3_be", 32'(bus.m_be), 32'h4);
            chk("t3_wdata", bus.m_wdata, 32'h00AB_0000);
         end
         if (bus.d_ready) pulses++;
      end
      chk("t3_pulses", 32'(pulses), 32'd1);

      // 4: simultaneous load and fetch
      force_lat = 1; gnt_log.delete();
      tick(); new_if(32'h44); new_d(1'b0, 4'hF, 32'h200, 32'h0); eval();
      repeat (10) cyc();
      chk("t4_grants", 32'(gnt_log.size()), 32'd2);
`ifndef MEM_ARB_RR_EN
      if (gnt_log.size() == 2) begin
         chk("t4_first", gnt_log[0], 32'h200);
         chk("t4_second", gnt_log[1], 32'h44);
      end
`endif

`ifdef MEM_ARB_RR_EN
      // 5: continuous ties after reset alternate starting with fetch
      tick(); reset = 0; eval();
      tick(); reset = 1; eval();
      gnt_log.delete(); force_lat = -1; if_rate = 100; d_rate = 100;
      for (int i = 0; i < 60 && gnt_log.size() < 4; i++) cyc();
      chk("t5_grants", 32'(gnt_log.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++)
         chk("t5_order", 32'(gnt_log[i][6]), 32'((i % 2) == 0));
      if_rate = 0; d_rate = 0;
      repeat (12) cyc();
`endif

      // 6: reset while a load is in flight, ack lands in the reset cycle
      force_lat = 3;
      tick(); new_d(1'b0, 4'hF, 32'h10, 32'h0); eval();
      cyc(); cyc();
      tick(); reset = 0; ack_force = 1; eval();
      chk("t6_d_ready", 32'(bus.d_ready), 32'd0);
      tick(); reset = 1; ack_force = 0; bus.d_req = 0; eval();
      chk("t6_m_req", 32'(bus.m_req), 32'd0);

      // random traffic with stray acks while idle
      force_lat = -1; junk_ack = 1; if_rate = 40; d_rate = 30;
      repeat (2000) cyc();
      if_rate = 0; d_rate = 0; junk_ack = 0;
      repeat (12) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
